// File: rtl/ldl_wrr_v1_if.sv
// Request-sharing bus between a set of requesters, a downstream sink and
// the weighted round-robin arbiter. The arbiter sits on the slave side.
interface ldl_wrr_v1_if #(
   parameter int BIN_WIDTH = 3,
   parameter int REQ_WIDTH = 1 << BIN_WIDTH,
   parameter int WGT_WIDTH = 4
);

   logic [REQ_WIDTH-1:0]           req;
   logic [REQ_WIDTH*WGT_WIDTH-1:0] wgt;
   logic                           ready;
   logic                           valid;
   logic [REQ_WIDTH-1:0]           ack;
   logic [BIN_WIDTH-1:0]           bin;
   logic                           last;

   // Requester/sink side: drives requests, quotas and sink acceptance.
   modport master (
      output req,
      output wgt,
      output ready,
      input  valid,
      input  ack,
      input  bin,
      input  last
   );

   // Arbiter side: observes requests and returns the grant.
   modport slave (
      input  req,
      input  wgt,
      input  ready,
      output valid,
      output ack,
      output bin,
      output last
   );

endinterface

// File: rtl/ldl_wrr_v1.sv
// Weighted round-robin arbiter with burst quotas. A grant is held for up to
// the owner's weight in accepted beats, or until the owner drops its request,
// then passes to the next eligible requester after the previous owner.
module ldl_wrr_v1 #(
   parameter int BIN_WIDTH = 3,
   parameter int REQ_WIDTH = 1 << BIN_WIDTH,
   parameter int WGT_WIDTH = 4
) (
   input logic           clk,
   input logic           rst_n,
   ldl_wrr_v1_if.slave   bus
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t                 state;
   state_t                 state_d;
   logic [BIN_WIDTH-1:0]   ptr;
   logic [BIN_WIDTH-1:0]   ptr_d;
   logic [WGT_WIDTH-1:0]   cnt;
   logic [WGT_WIDTH-1:0]   cnt_d;
   logic [REQ_WIDTH-1:0]   ack_q;
   logic [REQ_WIDTH-1:0]   ack_d;
   logic [BIN_WIDTH-1:0]   bin_q;
   logic [BIN_WIDTH-1:0]   bin_d;

   logic [REQ_WIDTH-1:0]   elig;
   logic [WGT_WIDTH-1:0]   wfield [REQ_WIDTH];
   logic                   found;
   logic [BIN_WIDTH-1:0]   win;
   logic [BIN_WIDTH-1:0]   idx;
   logic                   release_now;
   logic                   take;

   // A requester with a zero quota can never be granted, so it is treated as
   // not requesting at all.
   for (genvar g = 0; g < REQ_WIDTH; g++) begin : g_elig
      assign wfield[g] = bus.wgt[g*WGT_WIDTH +: WGT_WIDTH];
      assign elig[g]   = bus.req[g] & (|wfield[g]);
   end

   // Round-robin search: start just after the last owner and wrap, so the
   // last owner itself is considered only when nobody else is eligible.
   always_comb begin
      found = 1'b0;
      win   = ptr;
      idx   = ptr;
      for (int k = 1; k <= REQ_WIDTH; k++) begin
         idx = BIN_WIDTH'((int'(ptr) + k) % REQ_WIDTH);
         if (!found && elig[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   // Next-state logic: an abandon or an exhausted quota releases the grant,
   // and a release re-selects in the same edge so handover has no bubble.
   always_comb begin
      state_d     = state;
      ptr_d       = ptr;
      cnt_d       = cnt;
      ack_d       = ack_q;
      bin_d       = bin_q;
      release_now = 1'b0;
      take        = 1'b0;

      case (state)
         IDLE: begin
            take = found;
         end
         GRANT: begin
            release_now = !bus.req[bin_q] ||
                          (bus.ready && (cnt == WGT_WIDTH'(1)));
            if (release_now) begin
               if (found) begin
                  take = 1'b1;
               end else begin
                  state_d = IDLE;
                  ack_d   = '0;
               end
            end else if (bus.ready) begin
               cnt_d = cnt - WGT_WIDTH'(1);
            end
         end
         default: begin
            state_d = IDLE;
            ack_d   = '0;
         end
      endcase

      if (take) begin
         state_d    = GRANT;
         ptr_d      = win;
         bin_d      = win;
         cnt_d      = wfield[win];
         ack_d      = '0;
         ack_d[win] = 1'b1;
      end
   end

   // State register; reset parks the pointer on the top index so the first
   // search after reset begins at requester 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         ptr   <= BIN_WIDTH'(REQ_WIDTH - 1);
         cnt   <= '0;
         ack_q <= '0;
         bin_q <= '0;
      end else begin
         state <= state_d;
         ptr   <= ptr_d;
         cnt   <= cnt_d;
         ack_q <= ack_d;
         bin_q <= bin_d;
      end
   end

   assign bus.valid = (state == GRANT);
   assign bus.ack   = ack_q;
   assign bus.bin   = bin_q;
   assign bus.last  = (state == GRANT) && (cnt == WGT_WIDTH'(1));

endmodule
